// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// FSM state encoding and the counter-width function.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_fa.sv
// 1-bit full adder cell used by the serial datapath.
// Pure combinational sum and carry-out.
module FA (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, D = A - B, LSB first.
// One full-adder cell; B is inverted and the carry seeded with 1.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic b_inv;
  logic sum;
  logic cout;

  assign b_inv = ~b_q[0];

  FA u_fa (
    .A   (a_q[0]),
    .B   (b_inv),
    .Cin (carry_q),
    .S   (sum),
    .Cout(cout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          amsb_d  = A[WIDTH-1];
          bmsb_d  = B[WIDTH-1];
          carry_d = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d = cout;
        res_d   = {sum, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        // last bit: publish results so they are valid during DONE
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          dout_d   = {sum, res_q[WIDTH-1:1]};
          borrow_d = ~cout;
          ovf_d    = (amsb_q != bmsb_q) && (sum != amsb_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      dout_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign D      = dout_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule
